issue_scoreboard: RTL and testbench
===================================

ISSUE_SCOREBOARD -- requirements
Module: issue_scoreboard

Interface
REQ-001 SHALL have parameter MAX_INFLIGHT, default 3: max outstanding writes tracked per register (1..7).
REQ-002 SHALL have port clk  in  1  sole clock, all state on rising edge.
REQ-003 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports dec_valid in 1, dec_uses_rs in 1, dec_rs_addr in 5, dec_uses_rt in 1, dec_rt_addr in 5, dec_uses_rw in 1, dec_rw_addr in 5: decoded instruction fields.
REQ-005 SHALL have port dec_ready  out  1  decoded instruction accepted this cycle.
REQ-006 SHALL have port issue_valid  out  1  instruction presented to execute.
REQ-007 SHALL have port issue_ready  in  1  execute can accept.
REQ-008 SHALL have ports rel_valid in 1, rel_addr in 5: one pulse per retired or squashed issued writer.
REQ-009 SHALL have ports flush in 1 (kill the current decoded instruction), drain_req in 1 (stop issue, empty scoreboard).
REQ-010 SHALL have ports drained out 1, inflight out 8 (total outstanding writes), sb_error out 1 (sticky underflow).

Function
REQ-011 SHALL keep one up/down counter per register 1..31, width clog2(MAX_INFLIGHT+1); register 0 never tracked.
REQ-012 SHALL flag hazard when (dec_uses_rs and cnt[rs]!=0) or (dec_uses_rt and cnt[rt]!=0) or (dec_uses_rw and cnt[rw]==MAX_INFLIGHT).
REQ-013 SHALL drive issue_valid = dec_valid and not hazard and not flush and state==RUN, combinationally.
REQ-014 SHALL drive dec_ready = issue_ready and issue_valid; fire = issue_valid and issue_ready.
REQ-015 SHALL increment cnt[dec_rw_addr] on fire when dec_uses_rw and addr!=0.
REQ-016 SHALL decrement cnt[rel_addr] on rel_valid when addr!=0 and count nonzero.
REQ-017 SHALL leave count unchanged when increment and release hit the same register in one cycle.
REQ-018 SHALL ignore a release on a zero count and set sb_error, held until reset.
REQ-019 SHALL update inflight as the sum of all counters, registered, same cycle as counter update.
REQ-020 SHALL implement FSM RUN/DRAIN: RUN->DRAIN on drain_req; DRAIN->RUN when drain_req low and inflight==0.
REQ-021 SHALL assert drained = (state==DRAIN and inflight==0); no issue in DRAIN, releases still processed.
REQ-022 SHALL give flush priority over issue: no fire, no counter increment that cycle.
REQ-023 SHALL allow issue-to-dependent-issue no earlier than the cycle after the producer's release is seen (see REQ-028).

Reset
REQ-024 SHALL, on rst_n low, immediately clear all counters, inflight=0, sb_error=0, state=RUN.
REQ-025 SHALL hold issue_valid=0, dec_ready=0, drained=0 while rst_n low.
REQ-026 SHALL discard in-flight counts on reset mid-operation; later releases for them underflow-ignored per REQ-018.

Configuration
REQ-027 Macro SCOREBOARD_BYPASS_EN SHALL select same-cycle release bypass.
REQ-028 With it: a source whose count is 1 and released this cycle SHALL count as ready; without: hazard until the registered count reads 0 (one extra stall cycle).

Structure
REQ-029 SHALL place SbState enum (SB_RUN, SB_DRAIN) and SB_MAX_INFLIGHT_DEFAULT in mips_core_pkg; reuse MipsReg for addresses.
REQ-030 SHALL factor the per-register saturating up/down counter into sub-module sb_counter, 31 instances.

Verification
REQ-031 Writer rw=8 fires, then reader rs=8 -> stalls (dec_ready=0) until rel_valid addr 8; issues next cycle (same cycle with SCOREBOARD_BYPASS_EN).
REQ-032 Three writers to r5 with MAX_INFLIGHT=3, fourth writer r5 -> stalls; one release -> fourth issues, cnt[5]=3.
REQ-033 Fire writer r9 and release r9 same cycle with cnt[9]=1 -> cnt[9]=1, inflight unchanged.
REQ-034 drain_req with inflight=2 -> issue_valid=0, drained after second release, RUN resumes when drain_req drops.
REQ-035 rel_valid addr 12 with cnt[12]=0 -> no change, sb_error=1 until rst_n low.
REQ-036 rst_n low mid-stream with inflight=4 -> inflight=0, reader of stale register issues immediately after reset.

Source files
------------

// File: rtl/mips_core_pkg.sv
// +----------------------------------------------------------------------+
// | mips_core_pkg                                                        |
// | Shared types and constants for the MIPS core issue stage.            |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package mips_core_pkg;

  localparam int SB_MAX_INFLIGHT_DEFAULT = 3;

  typedef logic [4:0] MipsReg;

  typedef enum logic [0:0] {
    SB_RUN   = 1'b0,
    SB_DRAIN = 1'b1
  } SbState;

  // Counter width able to hold 0..max_inflight.
  function automatic int sb_cnt_width(input int max_inflight);
    return $clog2(max_inflight + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sb_counter.sv
// +----------------------------------------------------------------------+
// | sb_counter                                                           |
// | Saturating up/down outstanding-write counter for one register.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module sb_counter #(
  parameter int MAX_INFLIGHT = 3,
  parameter int WIDTH        = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             dec,
  output logic [WIDTH-1:0] cnt
);

  localparam logic [WIDTH-1:0] c_cnt_max = WIDTH'(MAX_INFLIGHT);

  logic [WIDTH-1:0] r_cnt;
  logic             w_nonzero;
  logic             w_up;
  logic             w_dn;

  assign w_nonzero = (r_cnt != '0);
  // A release of an empty counter is void, so a coincident increment still lands.
  assign w_up = inc && (r_cnt != c_cnt_max) && !(dec && w_nonzero);
  assign w_dn = dec && w_nonzero && !inc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_up) begin
      r_cnt <= r_cnt + WIDTH'(1);
    end else if (w_dn) begin
      r_cnt <= r_cnt - WIDTH'(1);
    end
  end

  assign cnt = r_cnt;

endmodule

`default_nettype wire

// File: rtl/issue_scoreboard.sv
// +----------------------------------------------------------------------+
// | issue_scoreboard                                                     |
// | Per-register outstanding-write scoreboard gating decode -> execute.  |
// | Option macro: SCOREBOARD_BYPASS_EN (same-cycle release bypass).      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module issue_scoreboard
  import mips_core_pkg::*;
#(
  parameter int MAX_INFLIGHT = SB_MAX_INFLIGHT_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       dec_valid,
  input  logic       dec_uses_rs,
  input  logic [4:0] dec_rs_addr,
  input  logic       dec_uses_rt,
  input  logic [4:0] dec_rt_addr,
  input  logic       dec_uses_rw,
  input  logic [4:0] dec_rw_addr,
  output logic       dec_ready,
  output logic       issue_valid,
  input  logic       issue_ready,
  input  logic       rel_valid,
  input  logic [4:0] rel_addr,
  input  logic       flush,
  input  logic       drain_req,
  output logic       drained,
  output logic [7:0] inflight,
  output logic       sb_error
);

  localparam int               c_cnt_w   = sb_cnt_width(MAX_INFLIGHT);
  localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(MAX_INFLIGHT);

  SbState             r_state;
  logic [7:0]         r_inflight;
  logic               r_sb_error;

  logic [c_cnt_w-1:0] w_cnt [32];
  logic [31:1]        w_inc_vec;
  logic [31:1]        w_dec_vec;

  logic [c_cnt_w-1:0] w_rs_cnt;
  logic [c_cnt_w-1:0] w_rt_cnt;
  logic [c_cnt_w-1:0] w_rw_cnt;
  logic [c_cnt_w-1:0] w_rel_cnt;
  logic               w_rs_clear;
  logic               w_rt_clear;
  logic               w_hazard;
  logic               w_fire;
  logic               w_inc_en;
  logic               w_rel_hit;
  logic               w_rel_ok;
  logic               w_underflow;

  assign w_cnt[0] = '0;

  generate
    for (genvar gi = 1; gi < 32; gi++) begin : g_counter
      assign w_inc_vec[gi] = w_inc_en && (dec_rw_addr == MipsReg'(gi));
      assign w_dec_vec[gi] = w_rel_ok && (rel_addr == MipsReg'(gi));

      sb_counter #(
        .MAX_INFLIGHT (MAX_INFLIGHT),
        .WIDTH        (c_cnt_w)
      ) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_inc_vec[gi]),
        .dec   (w_dec_vec[gi]),
        .cnt   (w_cnt[gi])
      );
    end
  endgenerate

  assign w_rs_cnt  = w_cnt[dec_rs_addr];
  assign w_rt_cnt  = w_cnt[dec_rt_addr];
  assign w_rw_cnt  = w_cnt[dec_rw_addr];
  assign w_rel_cnt = w_cnt[rel_addr];

`ifdef SCOREBOARD_BYPASS_EN
  localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);
  // The last outstanding writer retiring this cycle frees its readers now.
  assign w_rs_clear = (w_rs_cnt == '0) ||
                      ((w_rs_cnt == c_cnt_one) && rel_valid && (rel_addr == dec_rs_addr));
  assign w_rt_clear = (w_rt_cnt == '0) ||
                      ((w_rt_cnt == c_cnt_one) && rel_valid && (rel_addr == dec_rt_addr));
`else
  assign w_rs_clear = (w_rs_cnt == '0);
  assign w_rt_clear = (w_rt_cnt == '0);
`endif

  assign w_hazard = (dec_uses_rs && !w_rs_clear) ||
                    (dec_uses_rt && !w_rt_clear) ||
                    (dec_uses_rw && (w_rw_cnt == c_cnt_max));

  assign issue_valid = rst_n && dec_valid && !w_hazard && !flush && (r_state == SB_RUN);
  assign w_fire      = issue_valid && issue_ready;
  assign dec_ready   = w_fire;

  assign w_inc_en    = w_fire && dec_uses_rw && (dec_rw_addr != '0);
  assign w_rel_hit   = rel_valid && (rel_addr != '0);
  assign w_rel_ok    = w_rel_hit && (w_rel_cnt != '0);
  assign w_underflow = w_rel_hit && (w_rel_cnt == '0);

  // Running total tracks exactly the net change applied to the counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inflight <= '0;
      r_sb_error <= 1'b0;
    end else begin
      r_inflight <= r_inflight + 8'(w_inc_en) - 8'(w_rel_ok);
      r_sb_error <= r_sb_error || w_underflow;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= SB_RUN;
    end else begin
      case (r_state)
        SB_RUN: begin
          if (drain_req) r_state <= SB_DRAIN;
        end
        SB_DRAIN: begin
          if (!drain_req && (r_inflight == '0)) r_state <= SB_RUN;
        end
        default: r_state <= SB_RUN;
      endcase
    end
  end

  assign drained  = (r_state == SB_DRAIN) && (r_inflight == '0);
  assign inflight = r_inflight;
  assign sb_error = r_sb_error;

endmodule

`default_nettype wire

// File: tb/tb_issue_scoreboard.sv
// +----------------------------------------------------------------------+
// | tb_issue_scoreboard                                                  |
// | Directed + randomized bench for issue_scoreboard with array model.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_issue_scoreboard;

  localparam int MAXI = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       dec_valid = 1'b0, dec_uses_rs = 1'b0, dec_uses_rt = 1'b0, dec_uses_rw = 1'b0;
  logic [4:0] dec_rs_addr = '0, dec_rt_addr = '0, dec_rw_addr = '0;
  logic       issue_ready = 1'b0, rel_valid = 1'b0, flush = 1'b0, drain_req = 1'b0;
  logic [4:0] rel_addr = '0;
  logic       dec_ready, issue_valid, drained, sb_error;
  logic [7:0] inflight;

  always #5 clk = ~clk;

  issue_scoreboard #(.MAX_INFLIGHT(MAXI)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .dec_valid   (dec_valid),
    .dec_uses_rs (dec_uses_rs),
    .dec_rs_addr (dec_rs_addr),
    .dec_uses_rt (dec_uses_rt),
    .dec_rt_addr (dec_rt_addr),
    .dec_uses_rw (dec_uses_rw),
    .dec_rw_addr (dec_rw_addr),
    .dec_ready   (dec_ready),
    .issue_valid (issue_valid),
    .issue_ready (issue_ready),
    .rel_valid   (rel_valid),
    .rel_addr    (rel_addr),
    .flush       (flush),
    .drain_req   (drain_req),
    .drained     (drained),
    .inflight    (inflight),
    .sb_error    (sb_error)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: outstanding writes per register, drain mode, sticky error.
  int m_cnt [32];
  bit m_drain;
  bit m_err;

  logic [31:0] obs_ready, obs_valid, obs_drained, obs_inflight, obs_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int m_total();
    int s = 0;
    for (int i = 0; i < 32; i++) s += m_cnt[i];
    return s;
  endfunction

  function automatic bit m_src_clear(input logic [4:0] a);
    if (m_cnt[a] == 0) return 1'b1;
`ifdef SCOREBOARD_BYPASS_EN
    if (m_cnt[a] == 1 && rel_valid && rel_addr == a) return 1'b1;
`endif
    return 1'b0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_cnt[i] = 0;
    m_drain = 1'b0;
    m_err   = 1'b0;
  endtask

  task automatic drive(input bit dv, input bit urs, input int rs, input bit urt, input int rt,
                       input bit urw, input int rw, input bit ir, input bit rv, input int ra,
                       input bit fl, input bit dr);
    dec_valid = dv; dec_uses_rs = urs; dec_rs_addr = 5'(rs);
    dec_uses_rt = urt; dec_rt_addr = 5'(rt);
    dec_uses_rw = urw; dec_rw_addr = 5'(rw);
    issue_ready = ir; rel_valid = rv; rel_addr = 5'(ra);
    flush = fl; drain_req = dr;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Called just after a falling edge with inputs set; returns at the next falling edge.
  task automatic step(input string tag);
    bit hz, iv, fire, dn;
    int tot, inc_r, rel_r;
    #1;
    hz = (dec_uses_rs && !m_src_clear(dec_rs_addr)) ||
         (dec_uses_rt && !m_src_clear(dec_rt_addr)) ||
         (dec_uses_rw && m_cnt[dec_rw_addr] == MAXI);
    iv   = dec_valid && !hz && !flush && !m_drain;
    fire = iv && issue_ready;
    tot  = m_total();
    dn   = m_drain && (tot == 0);
    obs_valid = 32'(issue_valid); obs_ready = 32'(dec_ready); obs_drained = 32'(drained);
    obs_inflight = 32'(inflight); obs_err = 32'(sb_error);
    chk({tag, "/issue_valid"}, obs_valid, 32'(iv));
    chk({tag, "/dec_ready"}, obs_ready, 32'(fire));
    chk({tag, "/drained"}, obs_drained, 32'(dn));
    chk({tag, "/inflight"}, obs_inflight, 32'(tot));
    chk({tag, "/sb_error"}, obs_err, 32'(m_err));
    @(posedge clk);
    inc_r = (fire && dec_uses_rw && dec_rw_addr != 0) ? int'(dec_rw_addr) : 0;
    rel_r = 0;
    if (rel_valid && rel_addr != 0) begin
      if (m_cnt[rel_addr] == 0) m_err = 1'b1;
      else rel_r = int'(rel_addr);
    end
    if (!(inc_r != 0 && inc_r == rel_r)) begin
      if (inc_r != 0) m_cnt[inc_r]++;
      if (rel_r != 0) m_cnt[rel_r]--;
    end
    if (!m_drain) m_drain = drain_req;
    else if (!drain_req && tot == 0) m_drain = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    drive(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst/issue_valid", 32'(issue_valid), 0);
    chk("rst/dec_ready", 32'(dec_ready), 0);
    chk("rst/drained", 32'(drained), 0);
    chk("rst/inflight", 32'(inflight), 0);
    chk("rst/sb_error", 32'(sb_error), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int q[$];
    model_reset();
    @(negedge clk);
    do_reset();

    // Writer then dependent reader
    drive(1, 0, 0, 0, 0, 1, 8, 1, 0, 0, 0, 0); step("w8");
    chk("w8_fire", obs_ready, 1);
    drive(1, 1, 8, 0, 0, 0, 0, 1, 0, 0, 0, 0); step("rd8_stall");
    chk("rd8_stall", obs_ready, 0);
    drive(1, 1, 8, 0, 0, 0, 0, 1, 1, 8, 0, 0); step("rd8_rel");
`ifdef SCOREBOARD_BYPASS_EN
    chk("rd8_bypass", obs_ready, 1);
`else
    chk("rd8_rel_stall", obs_ready, 0);
    drive(1, 1, 8, 0, 0, 0, 0, 1, 0, 0, 0, 0); step("rd8_go");
    chk("rd8_go", obs_ready, 1);
`endif

    // Saturation at MAX_INFLIGHT writers to r5
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 0, 0, 1, 5, 1, 0, 0, 0, 0); step("w5");
      chk("w5_fire", obs_ready, 1);
    end
    drive(1, 0, 0, 0, 0, 1, 5, 1, 0, 0, 0, 0); step("w5_4th");
    chk("w5_4th_stall", obs_ready, 0);
    chk("w5_inflight3", obs_inflight, 3);
    drive(1, 0, 0, 0, 0, 1, 5, 1, 1, 5, 0, 0); step("w5_rel");
    drive(1, 0, 0, 0, 0, 1, 5, 1, 0, 0, 0, 0); step("w5_4th_go");
    chk("w5_4th_go", obs_ready, 1);
    idle(); step("w5_idle");
    chk("w5_inflight_full", obs_inflight, 3);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 5, 0, 0); step("rel5");
    end

    // Same-cycle increment and release on r9
    drive(1, 0, 0, 0, 0, 1, 9, 1, 0, 0, 0, 0); step("w9");
    drive(1, 0, 0, 0, 0, 1, 9, 1, 1, 9, 0, 0); step("w9_rel9");
    chk("w9_rel9_fire", obs_ready, 1);
    idle(); step("w9_idle");
    chk("w9_inflight", obs_inflight, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 0, 0); step("rel9");

    // Drain with two outstanding writes
    drive(1, 0, 0, 0, 0, 1, 10, 1, 0, 0, 0, 0); step("w10");
    drive(1, 0, 0, 0, 0, 1, 11, 1, 0, 0, 0, 0); step("w11");
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1); step("drain_req");
    chk("drain_inflight2", obs_inflight, 2);
    drive(1, 0, 0, 0, 0, 1, 12, 1, 0, 0, 0, 1); step("drain_blk");
    chk("drain_blk_valid", obs_valid, 0);
    chk("drain_blk_drained", obs_drained, 0);
    drive(1, 0, 0, 0, 0, 1, 12, 1, 1, 10, 0, 1); step("drain_rel10");
    drive(1, 0, 0, 0, 0, 1, 12, 1, 1, 11, 0, 1); step("drain_rel11");
    drive(1, 0, 0, 0, 0, 1, 12, 1, 0, 0, 0, 1); step("drain_empty");
    chk("drained_set", obs_drained, 1);
    chk("drained_valid", obs_valid, 0);
    drive(1, 0, 0, 0, 0, 1, 12, 1, 0, 0, 0, 0); step("drain_drop");
    chk("drain_drop_valid", obs_valid, 0);
    drive(1, 0, 0, 0, 0, 1, 12, 1, 0, 0, 0, 0); step("run_resume");
    chk("run_resume_valid", obs_valid, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 12, 0, 0); step("rel12");

    // Underflow is sticky until reset
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 12, 0, 0); step("uf12");
    idle(); step("uf_after");
    chk("uf_err", obs_err, 1);
    chk("uf_inflight", obs_inflight, 0);
    repeat (3) begin
      idle(); step("uf_hold");
    end
    chk("uf_err_hold", obs_err, 1);
    do_reset();

    // Reset mid-stream discards outstanding writes
    for (int r = 1; r <= 4; r++) begin
      drive(1, 0, 0, 0, 0, 1, r, 1, 0, 0, 0, 0); step("wmid");
    end
    idle(); step("mid_idle");
    chk("mid_inflight4", obs_inflight, 4);
    do_reset();
    drive(1, 1, 1, 1, 2, 0, 0, 1, 0, 0, 0, 0); step("stale_rd");
    chk("stale_rd_fire", obs_ready, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0); step("stale_rel");
    idle(); step("stale_after");
    chk("stale_rel_err", obs_err, 1);
    do_reset();

    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      bit rv;
      int ra;
      if (i == 750) do_reset();
      q.delete();
      for (int r = 1; r < 32; r++) if (m_cnt[r] > 0) q.push_back(r);
      rv = (q.size() > 0) && ($urandom_range(0, 99) < 45);
      ra = rv ? q[$urandom_range(0, q.size() - 1)] : 0;
      if ($urandom_range(0, 99) < 3) drain_req = !drain_req;
      drive($urandom_range(0, 99) < 80,
            1'($urandom), $urandom_range(0, 7),
            1'($urandom), $urandom_range(0, 7),
            1'($urandom), $urandom_range(0, 7),
            $urandom_range(0, 99) < 75, rv, ra,
            $urandom_range(0, 99) < 10, drain_req);
      step("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
